// File: rtl/step_ctrl.sv
// rtl/step_ctrl.sv - run/pause/single-step controller issuing tick-aligned step pulses
module step_ctrl #(
  parameter int   CNT_W        = 16,
  parameter logic SYNC_RST_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             run_btn,
  input  logic             step_btn,
  input  logic             halt,
  output logic             step_en,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] step_cnt,
  output logic             cnt_ovf
);

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       step_pend, step_pend_nxt;
  logic       issue;

  logic [1:0] run_sync, step_sync;
  logic       run_hist, step_hist;
  logic       run_ev, step_ev;

  // Button synchronizers, history registers and registered rising-edge events.
  // Reset loads SYNC_RST_VAL so a button held through reset is not seen as a new press.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_sync  <= {2{SYNC_RST_VAL}};
      step_sync <= {2{SYNC_RST_VAL}};
      run_hist  <= SYNC_RST_VAL;
      step_hist <= SYNC_RST_VAL;
      run_ev    <= 1'b0;
      step_ev   <= 1'b0;
    end else begin
      run_sync  <= {run_sync[0], run_btn};
      step_sync <= {step_sync[0], step_btn};
      run_hist  <= run_sync[1];
      step_hist <= step_sync[1];
      run_ev    <= run_sync[1] & ~run_hist;
      step_ev   <= step_sync[1] & ~step_hist;
    end
  end

  // FSM state and pending-step register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_PAUSE;
      step_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      step_pend <= step_pend_nxt;
    end
  end

  // Next state, pending-step update and step issue decision; halt beats every other event.
  always_comb begin
    state_nxt     = state;
    step_pend_nxt = step_pend;
    issue         = 1'b0;
    case (state)
      ST_PAUSE: begin
        if (halt) begin
          state_nxt     = ST_HALT;
          step_pend_nxt = 1'b0;
        end else begin
          issue = tick & step_pend;
          if (run_ev) begin
            state_nxt     = ST_RUN;
            step_pend_nxt = 1'b0;
          end else if (issue) begin
            // A step press landing on the issuing tick is dropped, not re-armed.
            step_pend_nxt = 1'b0;
          end else if (step_ev) begin
            step_pend_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        step_pend_nxt = 1'b0;
        if (halt) begin
          state_nxt = ST_HALT;
        end else begin
          // A run press on the tick pauses instead of stepping.
          issue = tick & ~run_ev;
          if (run_ev) state_nxt = ST_PAUSE;
        end
      end
      ST_HALT: begin
        step_pend_nxt = 1'b0;
      end
      default: begin
        state_nxt     = ST_PAUSE;
        step_pend_nxt = 1'b0;
      end
    endcase
  end

  // Registered outputs and saturating step counter with sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_en  <= 1'b0;
      running  <= 1'b0;
      halted   <= 1'b0;
      step_cnt <= '0;
      cnt_ovf  <= 1'b0;
    end else begin
      step_en <= issue;
      running <= (state_nxt == ST_RUN);
      halted  <= (state_nxt == ST_HALT);
      if (issue) begin
        if (&step_cnt) cnt_ovf <= 1'b1;
        else           step_cnt <= step_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_step_ctrl.sv
// tb/tb_step_ctrl.sv - directed self-checking bench for step_ctrl
module tb_step_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        run_btn = 1'b0;
  logic        step_btn = 1'b0;
  logic        halt = 1'b0;

  logic        step_en, running, halted, cnt_ovf;
  logic [15:0] step_cnt;
  logic        step_en4, running4, halted4, cnt_ovf4;
  logic [3:0]  step_cnt4;

  int n_checks = 0;
  int n_pass   = 0;
  int en_total = 0;
  int consec   = 0;
  logic en_prev = 1'b0;
  logic en_seen;
  int snap;

  step_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .run_btn(run_btn), .step_btn(step_btn),
    .halt(halt), .step_en(step_en), .running(running), .halted(halted),
    .step_cnt(step_cnt), .cnt_ovf(cnt_ovf)
  );

  step_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .tick(tick), .run_btn(run_btn), .step_btn(step_btn),
    .halt(halt), .step_en(step_en4), .running(running4), .halted(halted4),
    .step_cnt(step_cnt4), .cnt_ovf(cnt_ovf4)
  );

  always #5 clk = ~clk;

  // Count step pulses on the main instance and flag back-to-back pulses.
  always @(negedge clk) begin
    if (step_en) en_total++;
    if (step_en && en_prev) consec++;
    en_prev = step_en;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic go_run();
    run_btn = 1'b1;
    cyc(2);
    run_btn = 1'b0;
    cyc(5);
  endtask

  task automatic pulse_step();
    step_btn = 1'b1;
    cyc(2);
    step_btn = 1'b0;
    cyc(5);
  endtask

  // One-cycle tick; returns step_en just after the edge that sampled it, then spaces ticks.
  task automatic do_tick(output logic en);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    en = step_en;
    cyc(9);
  endtask

  initial begin
    cyc(1);
    do_reset();
    check("rst_step_en", 32'(step_en), 0);
    check("rst_running", 32'(running), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_step_cnt", 32'(step_cnt), 0);
    check("rst_cnt_ovf", 32'(cnt_ovf), 0);

    // Run press: running rises exactly at edge N+3, then three ticks each step once.
    run_btn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      check($sformatf("run_latency_e%0d", i - 1), 32'(running), (i == 4) ? 32'd1 : 32'd0);
    end
    run_btn = 1'b0;
    cyc(5);
    snap = en_total;
    for (int i = 0; i < 3; i++) begin
      do_tick(en_seen);
      check($sformatf("run_tick%0d_en", i), 32'(en_seen), 1);
    end
    check("run_en_pulses", 32'(en_total - snap), 3);
    check("run_step_cnt", 32'(step_cnt), 3);

    // Run press whose event lands on the tick: pause, no step, count unchanged.
    run_btn = 1'b1;
    cyc(1);
    run_btn = 1'b0;
    cyc(2);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    check("runev_tick_en", 32'(step_en), 0);
    check("runev_tick_running", 32'(running), 0);
    check("runev_tick_cnt", 32'(step_cnt), 3);

    // Two step presses before one tick merge into a single step.
    do_reset();
    pulse_step();
    pulse_step();
    snap = en_total;
    do_tick(en_seen);
    check("step_first_tick_en", 32'(en_seen), 1);
    do_tick(en_seen);
    do_tick(en_seen);
    check("step_merge_pulses", 32'(en_total - snap), 1);
    check("step_merge_cnt", 32'(step_cnt), 1);
    check("step_merge_running", 32'(running), 0);

    // Pending step issues; a step press landing on that same tick is dropped.
    pulse_step();
    step_btn = 1'b1;
    cyc(1);
    step_btn = 1'b0;
    cyc(2);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    check("step_drop_issue", 32'(step_en), 1);
    cyc(9);
    do_tick(en_seen);
    check("step_drop_no_rearm", 32'(en_seen), 0);
    check("step_drop_cnt", 32'(step_cnt), 2);

    // Halt in RUN: sticky until reset, buttons and ticks ignored.
    do_reset();
    go_run();
    halt = 1'b1;
    cyc(1);
    halt = 1'b0;
    check("halt_halted", 32'(halted), 1);
    check("halt_running", 32'(running), 0);
    go_run();
    pulse_step();
    snap = en_total;
    for (int i = 0; i < 5; i++) do_tick(en_seen);
    check("halt_no_steps", 32'(en_total - snap), 0);
    check("halt_still", 32'(halted), 1);
    do_reset();
    check("halt_cleared", 32'(halted), 0);

    // Reset coincident with tick while running suppresses the step.
    go_run();
    tick = 1'b1;
    rst = 1'b1;
    cyc(1);
    tick = 1'b0;
    rst = 1'b0;
    check("rst_tick_en", 32'(step_en), 0);
    check("rst_tick_running", 32'(running), 0);

    // 4-bit counter saturates at 15 and sets the sticky overflow flag on step 16.
    do_reset();
    go_run();
    for (int i = 1; i <= 17; i++) begin
      do_tick(en_seen);
      if (i == 15) begin
        check("sat_cnt_15", 32'(step_cnt4), 15);
        check("sat_ovf_15", 32'(cnt_ovf4), 0);
      end
      if (i == 16) begin
        check("sat_cnt_16", 32'(step_cnt4), 15);
        check("sat_ovf_16", 32'(cnt_ovf4), 1);
      end
    end
    check("sat_cnt_17", 32'(step_cnt4), 15);
    check("sat_ovf_17", 32'(cnt_ovf4), 1);
    check("wide_cnt_17", 32'(step_cnt), 17);
    check("wide_ovf_17", 32'(cnt_ovf), 0);

    // Run button held through reset release is not a press.
    run_btn = 1'b1;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(20);
    check("held_btn_running", 32'(running), 0);
    run_btn = 1'b0;
    cyc(6);
    check("held_btn_release", 32'(running), 0);

    check("no_consecutive_en", 32'(consec), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/step_ctrl.md
STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the step counter.
REQ-002 SHALL have parameter SYNC_RST_VAL, default 1'b1, giving the reset value of the button synchronizer and edge registers.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 tick  input  1  one-cycle pulse from the 1 Hz tick generator; level-high-for-one-cycle.
REQ-006 run_btn  input  1  asynchronous run/pause toggle button, active-high.
REQ-007 step_btn  input  1  asynchronous single-step button, active-high.
REQ-008 halt  input  1  synchronous level from the core; 1 = stop stepping.
REQ-009 step_en  output  1  registered one-cycle step pulse to the PC/fetch stage.
REQ-010 running  output  1  registered; 1 while FSM is in RUN.
REQ-011 halted  output  1  registered; 1 while FSM is in HALT.
REQ-012 step_cnt  output  CNT_W  registered count of issued step_en pulses.
REQ-013 cnt_ovf  output  1  registered sticky saturation flag.

Function
REQ-014 Each button SHALL pass through a 2-FF synchronizer plus one history register; rising-edge event = sync2 & ~hist.
REQ-015 Input first sampled high at edge N SHALL produce its edge event during cycle N+2 and the FSM SHALL act on it at edge N+3.
REQ-016 FSM states SHALL be PAUSE, RUN, HALT; encoding free.
REQ-017 PAUSE: run edge -> RUN; step edge -> set step_pend; otherwise hold.
REQ-018 RUN: run edge -> PAUSE; step edges ignored and SHALL NOT set step_pend.
REQ-019 halt sampled 1 in PAUSE or RUN SHALL move FSM to HALT at that edge, with priority over all other events.
REQ-020 HALT SHALL be left only by rst; buttons and tick ignored, step_pend cleared.
REQ-021 step_en SHALL be 1 in the cycle after the edge sampling tick=1 when either (FSM in RUN and no run edge and halt=0) or (FSM in PAUSE, step_pend=1, halt=0); otherwise 0.
REQ-022 Run edge coincident with tick while in RUN SHALL pause with no step issued.
REQ-023 Issuing a step from PAUSE SHALL clear step_pend at the same edge; step edge coincident with that tick SHALL be dropped (no re-arm).
REQ-024 Multiple step edges before a tick SHALL merge into one pending step (no queue).
REQ-025 Transition PAUSE->RUN SHALL clear step_pend.
REQ-026 step_cnt SHALL increment by 1 at the same edge step_en is registered 1.
REQ-027 step_cnt at all-ones SHALL saturate (no wrap) and set cnt_ovf, which stays 1 until rst.
REQ-028 step_en SHALL never be high on two consecutive cycles given a legal one-cycle tick.

Reset
REQ-029 rst=1 at an edge SHALL set FSM=PAUSE, step_en=0, running=0, halted=0, step_cnt=0, cnt_ovf=0, step_pend=0.
REQ-030 rst SHALL load synchronizer and history registers with SYNC_RST_VAL, so a button held through reset produces no edge after release.
REQ-031 rst asserted mid-RUN coincident with tick SHALL suppress step_en in the following cycle.

Verification
REQ-032 Reset, run_btn pulse 4 cycles, then 3 ticks 10 cycles apart -> running=1 from edge N+3, three step_en pulses, step_cnt=3.
REQ-033 PAUSE, step_btn pulsed twice before one tick, then 2 more ticks -> exactly one step_en, step_cnt=1.
REQ-034 RUN, run_btn edge event in the same cycle as tick -> running=0, no step_en, step_cnt unchanged.
REQ-035 RUN, halt=1 for one cycle, then run_btn and 5 ticks -> halted=1, running=0, zero further step_en until rst.
REQ-036 CNT_W=4, RUN, 17 ticks -> step_cnt=15 after the 15th tick, held at 15, cnt_ovf=1 from the 16th step.
REQ-037 run_btn held high across rst release for 20 cycles -> FSM remains PAUSE, running=0.
